// File: rtl/cachepool_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cachepool_pkg
// Description : Shared constants and the boot sequencer state type for the
//               CachePool cluster.
// Revision    : 1.0 - initial release
// ============================================================================
package cachepool_pkg;

  // Number of cores in the cluster; sets the width of the wake-up vector.
  localparam int unsigned NumCores = 16;

  // Base of the cluster peripheral region and the boot control register
  // offset inside it.
  localparam logic [47:0] PeriStartAddr     = 48'h0000_5100_0000;
  localparam logic [47:0] BootControlOffset = 48'h0000_0000_0058;
  localparam logic [47:0] BootCtrlAddr      = PeriStartAddr + BootControlOffset;

  // Boot sequencer states.
  typedef enum logic [2:0] {
    BOOT_IDLE = 3'd0,
    BOOT_WAIT = 3'd1,
    BOOT_REQ  = 3'd2,
    BOOT_RSP  = 3'd3,
    BOOT_WAKE = 3'd4,
    BOOT_RUN  = 3'd5,
    BOOT_DONE = 3'd6,
    BOOT_ERR  = 3'd7
  } boot_state_e;

endpackage
`default_nettype wire

// File: rtl/cachepool_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cachepool_boot_ctrl
// Description : Boot sequencer for the CachePool cluster. After a start
//               request it idles, writes the entry point to the cluster
//               BOOT_CONTROL register over reqrsp, pulses the core debug
//               lines and then counts run cycles until end-of-computation.
// Revision    : 1.0 - initial release
// ============================================================================
module cachepool_boot_ctrl #(
  parameter int unsigned          NumCores      = cachepool_pkg::NumCores,
  parameter int unsigned          AddrWidth     = 48,
  parameter logic [AddrWidth-1:0] BootAddr      = AddrWidth'(cachepool_pkg::BootCtrlAddr),
  parameter int unsigned          PreBootCycles = 1000,
  parameter int unsigned          RspTimeout    = 4096,
  parameter int unsigned          CntWidth      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          entry_point_i,
  output logic [AddrWidth-1:0] q_addr_o,
  output logic [31:0]          q_data_o,
  output logic                 q_write_o,
  output logic [3:0]           q_strb_o,
  output logic                 q_valid_o,
  input  logic                 q_ready_i,
  input  logic                 p_valid_i,
  input  logic                 p_error_i,
  output logic                 p_ready_o,
  output logic [NumCores-1:0]  debug_req_o,
  input  logic                 eoc_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [CntWidth-1:0]  cycles_o
);

  import cachepool_pkg::*;

  // Shared counter is wide enough for any int unsigned cycle parameter.
  localparam int unsigned      c_cnt_bits = 32;
  localparam logic [c_cnt_bits-1:0] c_pre_last =
    (PreBootCycles == 0) ? '0 : c_cnt_bits'(PreBootCycles - 1);
  localparam logic [c_cnt_bits-1:0] c_rsp_last =
    (RspTimeout == 0) ? '0 : c_cnt_bits'(RspTimeout - 1);

  boot_state_e           state_q, state_d;
  logic [c_cnt_bits-1:0] cnt_q, cnt_d;
  logic [31:0]           entry_q, entry_d;
  logic [CntWidth-1:0]   cycles_q, cycles_d;

  // State, shared counter, latched entry point and run counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= BOOT_IDLE;
      cnt_q    <= '0;
      entry_q  <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      entry_q  <= entry_d;
      cycles_q <= cycles_d;
    end
  end

  // Next-state logic; the shared counter times the pre-boot wait and then
  // the response timeout, the run counter saturates instead of wrapping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    entry_d  = entry_q;
    cycles_d = cycles_q;
    unique case (state_q)
      BOOT_IDLE, BOOT_DONE, BOOT_ERR: begin
        if (start_i) begin
          entry_d  = entry_point_i;
          cnt_d    = '0;
          cycles_d = '0;
          state_d  = (PreBootCycles == 0) ? BOOT_REQ : BOOT_WAIT;
        end
      end
      BOOT_WAIT: begin
        if (cnt_q == c_pre_last) begin
          cnt_d   = '0;
          state_d = BOOT_REQ;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      BOOT_REQ: begin
        if (q_ready_i) begin
          if (p_valid_i) begin
            state_d = p_error_i ? BOOT_ERR : BOOT_WAKE;
          end else begin
            cnt_d   = '0;
            state_d = BOOT_RSP;
          end
        end
      end
      BOOT_RSP: begin
        if (p_valid_i) begin
          state_d = p_error_i ? BOOT_ERR : BOOT_WAKE;
        end else if (cnt_q == c_rsp_last) begin
          state_d = BOOT_ERR;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      BOOT_WAKE: begin
        cnt_d   = '0;
        state_d = BOOT_RUN;
      end
      BOOT_RUN: begin
        if (eoc_i) begin
          state_d = BOOT_DONE;
        end else if (cycles_q != '1) begin
          cycles_d = cycles_q + CntWidth'(1);
        end
      end
      default: begin
        state_d = BOOT_IDLE;
      end
    endcase
  end

  // Moore output decode; everything idles at zero outside its own state so
  // reset drops the request asynchronously.
  always_comb begin
    q_addr_o    = '0;
    q_data_o    = '0;
    q_write_o   = 1'b0;
    q_strb_o    = 4'h0;
    q_valid_o   = 1'b0;
    p_ready_o   = 1'b0;
    debug_req_o = '0;
    done_o      = 1'b0;
    error_o     = 1'b0;
    busy_o      = 1'b1;
    unique case (state_q)
      BOOT_REQ: begin
        q_addr_o  = BootAddr;
        q_data_o  = entry_q;
        q_write_o = 1'b1;
        q_strb_o  = 4'hF;
        q_valid_o = 1'b1;
        p_ready_o = 1'b1;
      end
      BOOT_RSP:  p_ready_o = 1'b1;
      BOOT_WAKE: debug_req_o = '1;
      BOOT_IDLE: busy_o = 1'b0;
      BOOT_DONE: begin
        busy_o = 1'b0;
        done_o = 1'b1;
      end
      BOOT_ERR: begin
        busy_o  = 1'b0;
        error_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign cycles_o = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_cachepool_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cachepool_boot_ctrl
// Description : Self-checking bench for the CachePool boot sequencer. Two
//               instances share stimulus and differ only in run-counter
//               width so saturation is observed alongside the full count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cachepool_boot_ctrl;

  localparam int unsigned     P    = 10;
  localparam int unsigned     R    = 16;
  localparam int unsigned     NC   = 16;
  localparam logic [47:0]     BOOT = 48'h0000_5100_0058;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] entry_point_i = '0;
  logic        q_ready_i = 1'b0;
  logic        p_valid_i = 1'b0;
  logic        p_error_i = 1'b0;
  logic        eoc_i = 1'b0;

  logic [47:0]   q_addr;
  logic [31:0]   q_data;
  logic          q_write, q_valid, p_ready, busy, done, error;
  logic [3:0]    q_strb;
  logic [NC-1:0] dbg;
  logic [31:0]   cyc32;

  logic [47:0]   s_q_addr;
  logic [31:0]   s_q_data;
  logic          s_q_write, s_q_valid, s_p_ready, s_busy, s_done, s_error;
  logic [3:0]    s_q_strb;
  logic [NC-1:0] s_dbg;
  logic [3:0]    cyc4;

  int ntests = 0;
  int nfail  = 0;
  int hs_cnt = 0;
  int dbg_cnt = 0;

  always #5 clk = ~clk;

  cachepool_boot_ctrl #(
    .NumCores(NC), .AddrWidth(48), .BootAddr(BOOT),
    .PreBootCycles(P), .RspTimeout(R), .CntWidth(32)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .entry_point_i(entry_point_i),
    .q_addr_o(q_addr), .q_data_o(q_data), .q_write_o(q_write), .q_strb_o(q_strb),
    .q_valid_o(q_valid), .q_ready_i(q_ready_i), .p_valid_i(p_valid_i),
    .p_error_i(p_error_i), .p_ready_o(p_ready), .debug_req_o(dbg), .eoc_i(eoc_i),
    .busy_o(busy), .done_o(done), .error_o(error), .cycles_o(cyc32)
  );

  cachepool_boot_ctrl #(
    .NumCores(NC), .AddrWidth(48), .BootAddr(BOOT),
    .PreBootCycles(P), .RspTimeout(R), .CntWidth(4)
  ) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .entry_point_i(entry_point_i),
    .q_addr_o(s_q_addr), .q_data_o(s_q_data), .q_write_o(s_q_write), .q_strb_o(s_q_strb),
    .q_valid_o(s_q_valid), .q_ready_i(q_ready_i), .p_valid_i(p_valid_i),
    .p_error_i(p_error_i), .p_ready_o(s_p_ready), .debug_req_o(s_dbg), .eoc_i(eoc_i),
    .busy_o(s_busy), .done_o(s_done), .error_o(s_error), .cycles_o(cyc4)
  );

  // Count request handshakes and wake-up cycles of the main instance.
  always @(posedge clk) begin
    if (q_valid && q_ready_i) hs_cnt <= hs_cnt + 1;
    if (dbg != '0) dbg_cnt <= dbg_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full boot. mode: 0 ok via RSP, 1 ok same-cycle, 2 error via RSP,
  // 3 response timeout, 4 error same-cycle. qdly: ready stall cycles,
  // pdly: cycles between handshake and response, nrun: RUN cycles before eoc.
  task automatic boot(input int mode, input int qdly, input int pdly, input int nrun);
    logic [31:0] entry;
    int          lat;
    int          hs0;
    int          dbg0;
    logic        stray;
    logic        stable;
    logic [31:0] hold32;
    bit          same;
    bit          err;
    same  = (mode == 1) || (mode == 4);
    err   = (mode == 2) || (mode == 4);
    entry = $urandom;
    hs0   = hs_cnt;
    dbg0  = dbg_cnt;

    start_i = 1'b1;
    entry_point_i = entry;
    tick();
    start_i = 1'b0;
    entry_point_i = ~entry;
    check("busy_after_start", busy, 1'b1);
    check("flags_cleared", {done, error}, 2'b00);
    check("cycles_cleared", cyc32, 0);

    // Stray responses during the wait must be refused and ignored.
    lat = 1;
    stray = 1'b0;
    while (!q_valid && lat < 4 * P + 8) begin
      p_valid_i = 1'($urandom_range(0, 1));
      p_error_i = 1'($urandom_range(0, 1));
      stray = stray | p_ready;
      tick();
      lat++;
    end
    p_valid_i = 1'b0;
    p_error_i = 1'b0;
    check("start_to_req_latency", lat, P + 1);
    check("p_ready_outside_req", stray, 1'b0);

    stable = 1'b1;
    for (int i = 0; i < qdly; i++) begin
      if (!(q_valid === 1'b1 && q_addr === BOOT && q_data === entry &&
            q_strb === 4'hF && q_write === 1'b1 && p_ready === 1'b1)) stable = 1'b0;
      tick();
    end
    check("req_stable_under_stall", stable, 1'b1);
    check("req_addr", q_addr, BOOT);
    check("req_data", q_data, entry);
    check("req_strb_write", {q_strb, q_write}, {4'hF, 1'b1});

    q_ready_i = 1'b1;
    if (same) begin
      p_valid_i = 1'b1;
      p_error_i = err;
    end
    tick();
    q_ready_i = 1'b0;
    p_valid_i = 1'b0;
    p_error_i = 1'b0;
    check("one_handshake", hs_cnt - hs0, 1);
    check("q_valid_after_hs", q_valid, 1'b0);

    if (mode == 3) begin
      lat = 0;
      while (!error && lat < R + 8) begin
        tick();
        lat++;
      end
      check("timeout_cycles", lat, R);
    end else if (!same) begin
      for (int i = 0; i < pdly; i++) tick();
      check("rsp_waiting", {busy, error, p_ready}, 3'b101);
      p_valid_i = 1'b1;
      p_error_i = err;
      tick();
      p_valid_i = 1'b0;
      p_error_i = 1'b0;
    end

    if (err || mode == 3) begin
      check("error_o", error, 1'b1);
      check("err_not_busy_not_done", {busy, done}, 2'b00);
      repeat (3) tick();
      check("error_sticky", error, 1'b1);
      check("no_wake_on_error", dbg_cnt - dbg0, 0);
    end else begin
      check("wake_pulse", dbg, {NC{1'b1}});
      eoc_i = (nrun == 0);
      tick();
      check("wake_one_cycle", dbg, '0);
      for (int i = 0; i < nrun; i++) begin
        start_i = (i == nrun / 2);
        entry_point_i = $urandom;
        tick();
      end
      start_i = 1'b0;
      eoc_i = 1'b1;
      tick();
      eoc_i = 1'b0;
      check("done_o", {done, error, busy}, 3'b100);
      check("cycles_full", cyc32, nrun);
      check("cycles_sat4", cyc4, (nrun > 15) ? 15 : nrun);
      check("wake_once", dbg_cnt - dbg0, 1);
      hold32 = cyc32;
      for (int i = 0; i < 3; i++) begin
        eoc_i = 1'($urandom_range(0, 1));
        tick();
      end
      eoc_i = 1'b0;
      check("cycles_frozen", cyc32, hold32);
      check("done_sticky", done, 1'b1);
      check("busy_start_ignored", hs_cnt - hs0, 1);
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    tick();
    tick();
    check("reset_outputs", {q_valid, q_write, q_strb, p_ready, busy, done, error}, '0);
    check("reset_data", {q_addr, q_data, dbg}, '0);
    check("reset_cycles", cyc32, 0);
    rst = 1'b0;
    tick();

    boot(0, 1, 3, 50);   // nominal
    boot(0, 7, 2, 10);   // request backpressure
    boot(2, 0, 2, 0);    // error response
    boot(3, 2, 0, 0);    // response timeout
    boot(1, 0, 0, 5);    // same-cycle handshake and response
    boot(0, 0, 1, 0);    // eoc already high on RUN entry
    boot(0, 0, 1, 20);   // narrow counter saturates

    // Reset while the request is stalled, then boot again.
    start_i = 1'b1;
    entry_point_i = 32'h1234_5678;
    tick();
    start_i = 1'b0;
    lat = 0;
    while (!q_valid && lat < 4 * P) begin
      tick();
      lat++;
    end
    check("rst_test_reached_req", q_valid, 1'b1);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("rst_async_q_valid", q_valid, 1'b0);
    check("rst_async_outputs", {q_write, q_strb, p_ready, busy, done, error}, '0);
    check("rst_async_data", {q_addr, q_data, dbg}, '0);
    tick();
    rst = 1'b0;
    tick();
    boot(0, 3, 2, 12);

    for (int k = 0; k < 12; k++) begin
      boot(int'($urandom_range(0, 4)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 10)), int'($urandom_range(0, 60)));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
